// File: rtl/comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
//   state_e    : controller states (idle, running a compare, result pulse)
//   Default*   : default operand width and bits resolved per cycle
//   cnt_width  : width of the digit counter, wide enough to hold WIDTH/DIGIT
package comparator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDigit = 2;

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    return int'(unsigned'($clog2(width / digit))) + 1;
  endfunction

endpackage

// File: rtl/comp_digit.sv
// One cascade stage of an MSB-first magnitude compare.
//   preEQ, preGT : running result from the more significant slices
//   A, B         : current DIGIT-bit slices of the two operands
//   EQ, GT       : running result including this slice
// Once the upper slices differ, the decision is final and simply propagates.
module comp_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic             preEQ,
  input  logic             preGT,
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  output logic             EQ,
  output logic             GT
);

  always_comb begin
    EQ = preEQ;
    GT = preGT;
    if (preEQ) begin
      EQ = (A == B);
      GT = (A > B);
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle comparator resolving DIGIT bits of A versus B per clock, MSB first.
//   clock, reset         : single clock, synchronous active-high reset
//   start                : capture operands and begin (accepted when not running)
//   signed_mode          : 1 = two's-complement compare, sampled with the operands
//   data_a, data_b       : operands
//   busy                 : compare in progress
//   done                 : one-cycle pulse when eq/gt/lt have just been updated
//   eq, gt, lt           : registered result, held until the next compare finishes
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DIGIT = DefaultDigit
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned      N       = WIDTH / DIGIT;
  localparam int unsigned      CntW    = cnt_width(WIDTH, DIGIT);
  localparam logic [CntW-1:0]  CntLoad = CntW'(N);
  localparam logic [CntW-1:0]  CntLast = CntW'(1);
  localparam logic [WIDTH-1:0] MsbMask = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH % DIGIT) != 0 || !(DIGIT == 1 || DIGIT == 2 || DIGIT == 4)) begin : gen_bad_param
    $error("serial_comparator: WIDTH must be a multiple of DIGIT, DIGIT must be 1, 2 or 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_eq_q, run_eq_d, run_gt_q, run_gt_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             slice_eq, slice_gt;
  logic             accept;
  logic             last_slice;

  assign accept     = start && (state_q != StRun);
  assign last_slice = (state_q == StRun) && (cnt_q == CntLast);

  // Operands shift left so the slice under test always sits in the top DIGIT bits.
  comp_digit #(
    .DIGIT(DIGIT)
  ) u_comp_digit (
    .preEQ(run_eq_q),
    .preGT(run_gt_q),
    .A    (a_q[WIDTH-1 -: DIGIT]),
    .B    (b_q[WIDTH-1 -: DIGIT]),
    .EQ   (slice_eq),
    .GT   (slice_gt)
  );

  // State register and datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      run_eq_q <= 1'b0;
      run_gt_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      run_eq_q <= run_eq_d;
      run_gt_q <= run_gt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    run_eq_d = run_eq_q;
    run_gt_d = run_gt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    if (accept) begin
      // Flipping the sign bits maps two's-complement order onto unsigned order.
      a_d      = signed_mode ? (data_a ^ MsbMask) : data_a;
      b_d      = signed_mode ? (data_b ^ MsbMask) : data_b;
      cnt_d    = CntLoad;
      run_eq_d = 1'b1;
      run_gt_d = 1'b0;
    end else if (state_q == StRun) begin
      a_d      = a_q << DIGIT;
      b_d      = b_q << DIGIT;
      cnt_d    = cnt_q - CntLast;
      run_eq_d = slice_eq;
      run_gt_d = slice_gt;
      if (last_slice) begin
        eq_d = slice_eq;
        gt_d = slice_gt;
        lt_d = ~slice_eq & ~slice_gt;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    eq   = eq_q;
    gt   = gt_q;
    lt   = lt_q;
  end

endmodule

// File: tb/tb_serial_comparator.sv
module tb_serial_comparator;

  logic        clock;
  logic        reset;
  logic        start, signed_mode;
  logic [7:0]  data_a, data_b;
  logic        busy, done, eq, gt, lt;

  logic        start32, signed_mode32;
  logic [31:0] data_a32, data_b32;
  logic        busy32, done32, eq32, gt32, lt32;

  int checks = 0;
  int errors = 0;

  serial_comparator #(
    .WIDTH(8),
    .DIGIT(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .data_a     (data_a),
    .data_b     (data_b),
    .busy       (busy),
    .done       (done),
    .eq         (eq),
    .gt         (gt),
    .lt         (lt)
  );

  serial_comparator #(
    .WIDTH(32),
    .DIGIT(2)
  ) dut32 (
    .clock      (clock),
    .reset      (reset),
    .start      (start32),
    .signed_mode(signed_mode32),
    .data_a     (data_a32),
    .data_b     (data_b32),
    .busy       (busy32),
    .done       (done32),
    .eq         (eq32),
    .gt         (gt32),
    .lt         (lt32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives a start pulse across edge k; returns at the sample point of cycle k+1.
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clock);
    start       = 1'b1;
    data_a      = a;
    data_b      = b;
    signed_mode = sm;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    data_a = 8'h12;
    data_b = 8'h34;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b required busy=0 done=0", busy, done);
    end
    checks++;
    if ({eq, gt, lt} !== 3'b000) begin
      errors++;
      $display("FAIL reset_result: eq/gt/lt=%b required 000", {eq, gt, lt});
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    go(8'hA5, 8'hA4, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy cycle k+%0d: busy=%b done=%b required busy=1 done=0",
                 i, busy, done);
      end
      if (i < 4) @(negedge clock);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b required done=1 busy=0", done, busy);
    end
    checks++;
    if ({eq, gt, lt} !== 3'b010) begin
      errors++;
      $display("FAIL basic_result: eq/gt/lt=%b required 010", {eq, gt, lt});
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_modes();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vs [5];
    logic [2:0] vr [5];
    va[0] = 8'h80; vb[0] = 8'h01; vs[0] = 1'b1; vr[0] = 3'b001;
    va[1] = 8'h80; vb[1] = 8'h01; vs[1] = 1'b0; vr[1] = 3'b010;
    va[2] = 8'h3C; vb[2] = 8'h3C; vs[2] = 1'b0; vr[2] = 3'b100;
    va[3] = 8'h3C; vb[3] = 8'h3C; vs[3] = 1'b1; vr[3] = 3'b100;
    va[4] = 8'h7F; vb[4] = 8'h80; vs[4] = 1'b1; vr[4] = 3'b010;
    for (int v = 0; v < 5; v++) begin
      go(va[v], vb[v], vs[v]);
      repeat (4) @(negedge clock);
      checks++;
      if (done !== 1'b1 || {eq, gt, lt} !== vr[v]) begin
        errors++;
        $display("FAIL mode_vec%0d a=%h b=%h s=%b: done=%b eq/gt/lt=%b required done=1 %b",
                 v, va[v], vb[v], vs[v], done, {eq, gt, lt}, vr[v]);
      end
    end
  endtask

  task automatic test_ignore_start();
    go(8'h10, 8'h20, 1'b0);
    start  = 1'b1;
    data_a = 8'h20;
    data_b = 8'h10;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (done !== 1'b1 || {eq, gt, lt} !== 3'b001) begin
      errors++;
      $display("FAIL ignore_start: done=%b eq/gt/lt=%b required done=1 001", done, {eq, gt, lt});
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    logic seen_done;
    go(8'hFF, 8'h00, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {eq, gt, lt} !== 3'b000) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b eq/gt/lt=%b required 0 0 000",
               busy, done, {eq, gt, lt});
    end
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done pulse seen=%b required 0", seen_done);
    end
    checks++;
    if ({eq, gt, lt} !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: busy=%b eq/gt/lt=%b required 0 000", busy, {eq, gt, lt});
    end
  endtask

  task automatic test_back_to_back();
    go(8'h55, 8'h55, 1'b0);
    repeat (4) @(negedge clock);
    checks++;
    if (done !== 1'b1 || {eq, gt, lt} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_first: done=%b eq/gt/lt=%b required 1 100", done, {eq, gt, lt});
    end
    start  = 1'b1;
    data_a = 8'h00;
    data_b = 8'hFF;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b required 1 0", busy, done);
    end
    checks++;
    if ({eq, gt, lt} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_hold_at_capture: eq/gt/lt=%b required 100", {eq, gt, lt});
    end
    repeat (3) @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_early: done=%b busy=%b required 0 1", done, busy);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || {eq, gt, lt} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_second: done=%b eq/gt/lt=%b required 1 001", done, {eq, gt, lt});
    end
  endtask

  task automatic test_wide();
    @(negedge clock);
    start32       = 1'b1;
    data_a32      = 32'hFFFF_FFFF;
    data_b32      = 32'h0000_0000;
    signed_mode32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (15) @(negedge clock);
    checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b1) begin
      errors++;
      $display("FAIL wide_k16: done=%b busy=%b required 0 1", done32, busy32);
    end
    @(negedge clock);
    checks++;
    if (done32 !== 1'b1 || {eq32, gt32, lt32} !== 3'b001) begin
      errors++;
      $display("FAIL wide_k17: done=%b eq/gt/lt=%b required 1 001", done32, {eq32, gt32, lt32});
    end
    @(negedge clock);
    start32       = 1'b1;
    signed_mode32 = 1'b0;
    @(negedge clock);
    start32 = 1'b0;
    repeat (16) @(negedge clock);
    checks++;
    if (done32 !== 1'b1 || {eq32, gt32, lt32} !== 3'b010) begin
      errors++;
      $display("FAIL wide_unsigned: done=%b eq/gt/lt=%b required 1 010",
               done32, {eq32, gt32, lt32});
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    signed_mode   = 1'b0;
    data_a        = '0;
    data_b        = '0;
    start32       = 1'b0;
    signed_mode32 = 1'b0;
    data_a32      = '0;
    data_b32      = '0;
    test_reset();
    test_basic();
    test_modes();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
